frame_stream_reader: RTL

Reads one full RGB565 frame from a frame-buffer BRAM in raster order and replays it as the single-cycle write stream (we / wAddr / wData) that the image filters consume. It drives the filter input side, feeding Sharpen_Filter and similar filters from stored memory instead of the camera. A frame starts on a start pulse, can be paced by a hold input, and ends with a done pulse.

---
 rtl/img_pkg.sv | 26 ++
 rtl/pipe_delay.sv | 38 +++
 rtl/frame_stream_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared image-path constants and types for the frame-buffer readers and filters.
package img_pkg;

  localparam int unsigned ADDR_W         = 17;
  localparam int unsigned PIX_W          = 16;
  localparam int unsigned IMG_WIDTH_DEF  = 320;
  localparam int unsigned IMG_HEIGHT_DEF = 240;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

  // Counter width for a range of n values; never zero so 1-pixel dimensions still elaborate.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register chain with synchronous reset; DEPTH of 0 is a straight wire.
module pipe_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else begin : g_chain
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      logic [WIDTH-1:0] q;
      if (s == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            q <= '0;
          end else begin
            q <= din;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (reset) begin
            q <= '0;
          end else begin
            q <= g_stage[s-1].q;
          end
        end
      end
    end
    assign dout = g_stage[DEPTH-1].q;
  end

endmodule

// File: rtl/frame_stream_reader.sv
// Replays one RGB565 frame from a frame-buffer BRAM in raster order as a single-cycle
// we/wAddr/wData pixel stream, paced by hold and bracketed by start/done.
module frame_stream_reader
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [PIX_W-1:0]  rData,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [PIX_W-1:0]  wData,
  output logic              eol,
  output logic              eof
);

  localparam int unsigned COL_W = cnt_w(IMG_WIDTH);
  localparam int unsigned ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam int unsigned TAG_W = ADDR_W + 3;

  rd_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              col_end;
  logic              frame_end;

  logic [TAG_W-1:0]  tag_in;
  logic [TAG_W-1:0]  tag_out;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic              tag_eol;
  logic              tag_eof;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  rgb565_t           wdata_q;
  logic              eol_q;
  logic              eof_q;

  // Line/frame boundaries come from the row/column counters, not the flat address.
  assign col_end   = (col_q == COL_LAST);
  assign frame_end = col_end && (row_q == ROW_LAST);

  assign rd_en = (state_q == READ) && !hold;
  assign rAddr = addr_q;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= READ;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        READ: begin
          if (!hold) begin
            if (frame_end) begin
              state_q <= DRAIN;
              addr_q  <= '0;
              col_q   <= '0;
              row_q   <= '0;
            end else begin
              addr_q <= addr_q + 1'b1;
              if (col_end) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (we_q && eof_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read tags travel alongside the BRAM so they line up with rData.
  assign tag_in = {rd_en, addr_q, col_end, frame_end};

  pipe_delay #(
    .WIDTH(TAG_W),
    .DEPTH(RD_LATENCY)
  ) u_tag_delay (
    .clk  (clk),
    .reset(reset),
    .din  (tag_in),
    .dout (tag_out)
  );

  assign {tag_valid, tag_addr, tag_eol, tag_eof} = tag_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      we_q  <= tag_valid;
      eol_q <= tag_valid && tag_eol;
      eof_q <= tag_valid && tag_eof;
      if (tag_valid) begin
        waddr_q <= tag_addr;
        wdata_q <= rgb565_t'(rData);
      end
    end
  end

  assign we    = we_q;
  assign wAddr = waddr_q;
  assign wData = wdata_q;
  assign eol   = eol_q;
  assign eof   = eof_q;
  assign done  = we_q && eof_q;

endmodule
